// File: rtl/geofence_poly.sv
// Point-in-convex-polygon checker: loads a target and N vertices, sorts them CCW
// around vertex 0 with a bubble sort, then tests the target against one edge per cycle.
module geofence_poly #(
    parameter int COORD_W   = 10,
    parameter int MAX_VERTS = 8,
    parameter int NV_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [NV_W-1:0]    num_verts,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               is_inside,
    output logic               on_edge,
    output logic               busy
);
    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int CW = 2 * COORD_W + 3;
    localparam int IW = $clog2(MAX_VERTS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SORT = 3'd2;
    localparam logic [2:0] S_TEST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic signed [DW-1:0] f_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // ax*by - bx*ay at full precision
    function automatic logic signed [CW-1:0] f_cross(input logic signed [DW-1:0] ax,
                                                     input logic signed [DW-1:0] ay,
                                                     input logic signed [DW-1:0] bx,
                                                     input logic signed [DW-1:0] by);
        logic signed [PW-1:0] p0;
        logic signed [PW-1:0] p1;
        p0 = PW'(ax) * PW'(by);
        p1 = PW'(bx) * PW'(ay);
        return CW'(p0) - CW'(p1);
    endfunction

    logic [2:0]         r_state;
    logic [COORD_W-1:0] r_vx [MAX_VERTS];
    logic [COORD_W-1:0] r_vy [MAX_VERTS];
    logic [COORD_W-1:0] r_px, r_py;
    logic [IW-1:0]      r_last, r_last2, r_cnt, r_i, r_pass, r_k;
    logic               r_swapped, r_all_pos, r_any_neg;

    logic [NV_W-1:0]     w_n;
    logic                w_xfer, w_swap, w_flag, w_pos, w_neg;
    logic [IW-1:0]       w_i1, w_k1;
    logic signed [CW-1:0] w_c, w_e;

    always_comb begin
        w_n = num_verts;
        if (num_verts < NV_W'(3))
            w_n = NV_W'(3);
        else if (num_verts > NV_W'(MAX_VERTS))
            w_n = NV_W'(MAX_VERTS);
    end

    assign in_ready  = !reset && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_xfer    = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign is_inside = out_valid && r_all_pos;
    assign on_edge   = out_valid && !r_all_pos && !r_any_neg;
    assign busy      = (r_state != S_IDLE);

    assign w_i1 = r_i + IW'(1);
    assign w_k1 = (r_k == r_last) ? '0 : r_k + IW'(1);

    assign w_c = f_cross(f_diff(r_vx[r_i], r_vx[0]),  f_diff(r_vy[r_i], r_vy[0]),
                         f_diff(r_vx[w_i1], r_vx[0]), f_diff(r_vy[w_i1], r_vy[0]));
    assign w_e = f_cross(f_diff(r_vx[w_k1], r_vx[r_k]), f_diff(r_vy[w_k1], r_vy[r_k]),
                         f_diff(r_px, r_vx[r_k]),       f_diff(r_py, r_vy[r_k]));

    assign w_swap = w_c[CW-1];
    assign w_flag = r_swapped || w_swap;
    assign w_neg  = w_e[CW-1];
    assign w_pos  = !w_e[CW-1] && (|w_e);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_px      <= '0;
            r_py      <= '0;
            r_last    <= '0;
            r_last2   <= '0;
            r_cnt     <= '0;
            r_i       <= '0;
            r_pass    <= '0;
            r_k       <= '0;
            r_swapped <= 1'b0;
            r_all_pos <= 1'b0;
            r_any_neg <= 1'b0;
            for (int v = 0; v < MAX_VERTS; v++) begin
                r_vx[v] <= '0;
                r_vy[v] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    r_px    <= in_x;
                    r_py    <= in_y;
                    r_last  <= IW'(w_n - NV_W'(1));
                    r_last2 <= IW'(w_n - NV_W'(2));
                    r_cnt   <= '0;
                    r_state <= S_LOAD;
                end
                S_LOAD: if (w_xfer) begin
                    r_vx[r_cnt] <= in_x;
                    r_vy[r_cnt] <= in_y;
                    r_cnt       <= r_cnt + IW'(1);
                    if (r_cnt == r_last) begin
                        r_i       <= IW'(1);
                        r_pass    <= '0;
                        r_swapped <= 1'b0;
                        r_all_pos <= 1'b1;
                        r_any_neg <= 1'b0;
                        r_state   <= S_SORT;
                    end
                end
                S_SORT: begin
                    if (w_swap) begin
                        r_vx[r_i]  <= r_vx[w_i1];
                        r_vy[r_i]  <= r_vy[w_i1];
                        r_vx[w_i1] <= r_vx[r_i];
                        r_vy[w_i1] <= r_vy[r_i];
                    end
                    if (r_i != r_last2) begin
                        r_i       <= w_i1;
                        r_swapped <= w_flag;
                    end else if (!w_flag || r_pass == r_last2) begin
                        // clean pass, or N-1 passes done: bounded even for degenerate input
                        r_k     <= '0;
                        r_state <= S_TEST;
                    end else begin
                        r_pass    <= r_pass + IW'(1);
                        r_i       <= IW'(1);
                        r_swapped <= 1'b0;
                    end
                end
                S_TEST: begin
                    r_all_pos <= r_all_pos && w_pos;
                    r_any_neg <= r_any_neg || w_neg;
                    r_k       <= w_k1;
                    if (r_k == r_last)
                        r_state <= S_DONE;
                end
                S_DONE: if (out_ready)
                    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench for geofence_poly: hand-computed polygon cases, clamping,
// backpressure and mid-frame reset.
module tb_geofence_poly;
    localparam int COORD_W = 10;
    localparam int MAX_VERTS = 8;
    localparam int NV_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COORD_W-1:0] in_x = '0;
    logic [COORD_W-1:0] in_y = '0;
    logic [NV_W-1:0]    num_verts = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               is_inside;
    logic               on_edge;
    logic               busy;

    int npass = 0;
    int nchk  = 0;

    geofence_poly #(.COORD_W(COORD_W), .MAX_VERTS(MAX_VERTS), .NV_W(NV_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .num_verts(num_verts), .out_valid(out_valid),
        .out_ready(out_ready), .is_inside(is_inside), .on_edge(on_edge), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // one beat; returns after the transferring edge (+1)
    task automatic beat(input int x, input int y, input int nv);
        bit ok;
        ok = 0;
        in_valid  = 1'b1;
        in_x      = COORD_W'(x);
        in_y      = COORD_W'(y);
        num_verts = NV_W'(nv);
        for (int c = 0; c < 50 && !ok; c++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("beat_timeout", 0, 1);
    endtask

    task automatic wait_result(input string tag, input int exp_in, input int exp_edge);
        bit got;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (out_valid) got = 1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_valid"}, int'(got), 1);
        check({tag, "_inside"}, int'(is_inside), exp_in);
        check({tag, "_edge"}, int'(on_edge), exp_edge);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ready_after"}, int'(in_ready), 1);
        check({tag, "_valid_after"}, int'(out_valid), 0);
    endtask

    task automatic square(input int px, input int py);
        beat(px, py, 4);
        beat(0, 0, 4);
        beat(10, 10, 4);
        beat(10, 0, 4);
        beat(0, 10, 4);
    endtask

    initial begin
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_inside", int'(is_inside), 0);
        check("rst_edge", int'(on_edge), 0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", int'(in_ready), 1);

        square(5, 5);
        wait_result("sq_in", 1, 0);
        accept("sq_in");

        square(10, 5);
        wait_result("sq_edge", 0, 1);
        accept("sq_edge");

        square(11, 5);
        wait_result("sq_out", 0, 0);
        accept("sq_out");

        // hexagon supplied in reverse order, max-range coordinates
        beat(512, 512, 6);
        beat(768, 0, 6);    beat(256, 0, 6);     beat(0, 512, 6);
        beat(256, 1023, 6); beat(768, 1023, 6);  beat(1023, 512, 6);
        wait_result("hex_in", 1, 0);
        accept("hex_in");

        beat(1023, 1023, 6);
        beat(768, 0, 6);    beat(256, 0, 6);     beat(0, 512, 6);
        beat(256, 1023, 6); beat(768, 1023, 6);  beat(1023, 512, 6);
        wait_result("hex_out", 0, 0);
        accept("hex_out");

        // num_verts=2 clamps to 3: four beats, then in_ready drops
        beat(2, 2, 2);
        beat(0, 0, 2); beat(10, 0, 7); beat(0, 10, 7);
        check("clamp3_ready", int'(in_ready), 0);
        check("clamp3_busy", int'(busy), 1);
        wait_result("clamp3", 1, 0);
        accept("clamp3");

        // num_verts=15 clamps to 8: nine beats
        beat(6, 6, 15);
        beat(4, 0, 15);  beat(12, 8, 3);  beat(0, 4, 3);  beat(8, 0, 3);
        beat(8, 12, 3);  beat(0, 8, 3);   beat(12, 4, 3);
        check("clamp8_ready_mid", int'(in_ready), 1);
        beat(4, 12, 3);
        check("clamp8_ready_end", int'(in_ready), 0);
        wait_result("clamp8", 1, 0);
        accept("clamp8");

        beat(1, 1, 3);
        beat(0, 0, 3); beat(1023, 0, 3); beat(0, 1023, 3);
        wait_result("tri", 1, 0);

        // hold the result under backpressure
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_inside", int'(is_inside), 1);
            check("bp_edge", int'(on_edge), 0);
            check("bp_in_ready", int'(in_ready), 0);
        end
        accept("bp");
        square(10, 5);
        wait_result("b2b", 0, 1);
        accept("b2b");

        // reset during SORT
        square(5, 5);
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(in_ready), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", int'(in_ready), 1);
        square(11, 5);
        wait_result("post_rst", 0, 0);
        accept("post_rst");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
